memref_rd_arbiter: RTL and testbench

MEMREF_RD_ARBITER -- requirements
Module: memref_rd_arbiter

---
 rtl/memref_arb_pkg.sv | 25 ++
 rtl/memref_rd_arbiter_rr_select.sv | 21 ++
 rtl/memref_rd_arbiter.sv | 90 +++++++++
 tb/tb_memref_rd_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memref_arb_pkg.sv
// memref_arb_pkg: requester index type, grant-counter width and the round-robin pick function
package memref_arb_pkg;

    typedef logic [2:0] req_idx_t;

    typedef struct packed {
        logic     vld;
        req_idx_t idx;
    } pick_t;

    localparam int CNT_W = 16;

    // Scans downward so the requester closest to ptr (modulo n) is written last and wins.
    function automatic pick_t rr_pick(input logic [7:0] req, input req_idx_t ptr, input int n);
        pick_t p;
        int    s;
        p = '0;
        for (int k = 7; k >= 0; k--) begin
            s = (int'(ptr) + k) % n;
            if (k < n && req[s[2:0]]) p = '{vld: 1'b1, idx: s[2:0]};
        end
        return p;
    endfunction

endpackage

// File: rtl/memref_rd_arbiter_rr_select.sv
// rr_select: combinational priority rotate turning a request vector and rr pointer into a one-hot grant
module rr_select
    import memref_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_ptr,
    output logic [N-1:0] o_gnt,
    output logic         o_vld,
    output logic [2:0]   o_idx
);

    pick_t w_pick;

    assign w_pick = rr_pick(8'(i_req), i_ptr, N);
    assign o_vld  = w_pick.vld;
    assign o_idx  = w_pick.idx;
    assign o_gnt  = w_pick.vld ? N'(1) << w_pick.idx : '0;

endmodule

// File: rtl/memref_rd_arbiter.sv
// memref_rd_arbiter: round-robin read arbiter onto one shared memory port with a 1-deep response tag.
// Define MEMREF_ARB_STATS_EN to build the saturating per-requester grant counters.
module memref_rd_arbiter
    import memref_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    parameter int  SIZE    = 8,
    localparam int ADDR_W  = $clog2(SIZE)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic                      o_mem_rd_en,
    output logic [ADDR_W-1:0]         o_mem_addr,
    input  logic                      i_mem_dout_valid,
    input  logic [WIDTH-1:0]          i_mem_dout,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [WIDTH-1:0]          o_rsp_data,
    output logic                      o_err,
    output logic [NUM_REQ*CNT_W-1:0]  o_grant_cnt
);

    logic [2:0]        r_rr_ptr;
    logic [2:0]        r_tag;
    logic              r_tag_vld;
    logic              r_err;
    logic              r_rst_q;
    logic              w_vld;
    logic [2:0]        w_idx;
    logic [ADDR_W-1:0] w_addr_arr [8];

    // Masking the requests during reset forces gnt, mem_rd_en and the tag capture to zero.
    rr_select #(.N(NUM_REQ)) u_rr_select (
        .i_req (i_req & {NUM_REQ{i_rst_n}}),
        .i_ptr (r_rr_ptr),
        .o_gnt (o_gnt),
        .o_vld (w_vld),
        .o_idx (w_idx)
    );

    for (genvar g = 0; g < 8; g++) begin : g_addr
        if (g < NUM_REQ) begin : g_used
            assign w_addr_arr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
        end else begin : g_pad
            assign w_addr_arr[g] = '0;
        end
    end

    assign o_mem_rd_en = w_vld;
    assign o_mem_addr  = w_vld ? w_addr_arr[w_idx] : '0;
    assign o_rsp_valid = (i_rst_n && i_mem_dout_valid && r_tag_vld) ? NUM_REQ'(1) << r_tag : '0;
    assign o_rsp_data  = i_mem_dout;
    assign o_err       = r_err;

    // r_rst_q masks the first cycle after reset so a read issued just before reset can land silently.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_ptr  <= '0;
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
            r_err     <= 1'b0;
            r_rst_q   <= 1'b1;
        end else begin
            r_rst_q   <= 1'b0;
            r_tag_vld <= w_vld;
            if (w_vld) begin
                r_tag    <= w_idx;
                r_rr_ptr <= (w_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_idx + 3'd1;
            end
            r_err <= r_err | (i_mem_dout_valid & ~r_tag_vld & ~r_rst_q) | (r_tag_vld & ~i_mem_dout_valid);
        end
    end

`ifdef MEMREF_ARB_STATS_EN
    for (genvar c = 0; c < NUM_REQ; c++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) r_cnt <= '0;
            else if (o_gnt[c] && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
        assign o_grant_cnt[c*CNT_W +: CNT_W] = r_cnt;
    end
`else
    assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_memref_rd_arbiter.sv
// tb_memref_rd_arbiter: directed stimulus, a behavioural arbiter/memory model checked every cycle, and literal pins
module tb_memref_rd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int S  = 8;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic            mem_v;
    logic [W-1:0]    mem_dout;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic            err;
    logic [N*16-1:0] grant_cnt;

    logic [W-1:0] mem [S];
    logic         inj     = 1'b0;
    logic         mem_off = 1'b0;
    int           checks  = 0;
    int           errors  = 0;

    int m_ptr  = 0;
    int m_err  = 0;
    int m_post = 0;
    int m_cnt [N];
    int q_id [$];
    int q_ad [$];

    always #5 clk = ~clk;

    memref_rd_arbiter #(.NUM_REQ(N), .WIDTH(W), .SIZE(S)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req            (req),
        .i_req_addr       (req_addr),
        .o_gnt            (gnt),
        .o_mem_rd_en      (mem_rd_en),
        .o_mem_addr       (mem_addr),
        .i_mem_dout_valid (mem_v),
        .i_mem_dout       (mem_dout),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_data       (rsp_data),
        .o_err            (err),
        .o_grant_cnt      (grant_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: first requester at/after the pointer wins; each grant owes exactly one response next cycle.
    always @(negedge clk) begin
        int            w;
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        logic [AW-1:0] ea;
        logic [63:0]   ec;
        w  = -1;
        eg = '0;
        er = '0;
        ea = '0;
        if (rst_n) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && ((req >> ((m_ptr + k) % N)) & N'(1)) != '0) w = (m_ptr + k) % N;
            if (w >= 0) begin
                eg = N'(1) << w;
                ea = AW'(req_addr >> (w * AW));
            end
            if (mem_v && q_id.size() > 0) er = N'(1) << q_id[0];
        end
        chk("gnt", gnt, eg);
        chk("mem_rd_en", mem_rd_en, |eg);
        chk("mem_addr", mem_addr, ea);
        chk("rsp_valid", rsp_valid, er);
        chk("err", err, 64'(m_err));
        if (er != '0) chk("rsp_data", rsp_data, mem[q_ad[0]]);
        for (int k = 0; k < N; k++) begin
`ifdef MEMREF_ARB_STATS_EN
            ec = m_cnt[k] > 65535 ? 64'hFFFF : 64'(m_cnt[k]);
`else
            ec = 64'h0;
`endif
            chk("grant_cnt", 64'(grant_cnt >> (16 * k)) & 64'hFFFF, ec);
        end
        if (!rst_n) begin
            m_ptr  = 0;
            m_err  = 0;
            m_post = 1;
            q_id.delete();
            q_ad.delete();
            for (int k = 0; k < N; k++) m_cnt[k] = 0;
        end else begin
            if (mem_v && q_id.size() == 0 && m_post == 0) m_err = 1;
            if (!mem_v && q_id.size() > 0) m_err = 1;
            if (q_id.size() > 0) begin
                void'(q_id.pop_front());
                void'(q_ad.pop_front());
            end
            if (w >= 0) begin
                q_id.push_back(w);
                q_ad.push_back(int'(ea));
                m_ptr = (w + 1) % N;
                m_cnt[w]++;
            end
            m_post = 0;
        end
    end

    // One cycle: literal checks (-1 skips) at negedge, then the memory answers last cycle's read.
    task automatic cyc(input int eg, input int er, input int ee);
        logic          rd;
        logic [AW-1:0] ad;
        @(negedge clk);
        if (eg >= 0) chk("lit_gnt", gnt, 64'(eg));
        if (er >= 0) chk("lit_rsp_valid", rsp_valid, 64'(er));
        if (ee >= 0) chk("lit_err", err, 64'(ee));
        rd = mem_rd_en && !mem_off;
        ad = mem_addr;
        @(posedge clk);
        #1;
        mem_v    = rd | inj;
        mem_dout = mem[ad];
        inj      = 1'b0;
    endtask

    int g36 [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    int r36 [8] = '{0, 1, 2, 4, 8, 1, 2, 4};
    logic [N-1:0] pats [8] = '{4'b1010, 4'b0110, 4'b1001, 4'b0011, 4'b1100, 4'b0111, 4'b1110, 4'b1011};

`ifdef MEMREF_ARB_STATS_EN
    localparam int NG = 70000;
    localparam logic [15:0] CNT1 = 16'hFFFF;
`else
    localparam int NG = 300;
    localparam logic [15:0] CNT1 = 16'h0000;
`endif

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        mem_v    = 1'b0;
        mem_dout = '0;
        for (int i = 0; i < S; i++) mem[i] = 32'hC0DE_0000 + i * 32'h111;
        cyc(0, 0, 0);
        req = '1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        req   = '0;
        rst_n = 1'b1;
        repeat (5) cyc(0, 0, 0);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) cyc(g36[i], r36[i], 0);
        req = '0;
        cyc(0, 8, 0);
        cyc(0, 0, 0);
        req_addr = {3'd6, 3'd4, 3'd7, 3'd5};
        for (int i = 0; i < 8; i++) begin
            req = pats[i];
            cyc(-1, -1, 0);
        end
        req = '0;
        cyc(-1, -1, 0);
        rst_n = 1'b0;
        cyc(0, 0, 0);
        rst_n    = 1'b1;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        req = 4'b0001;
        cyc(1, 0, 0);
        req = 4'b0101;
        cyc(4, 1, 0);
        cyc(1, 4, 0);
        cyc(4, 1, 0);
        req = '0;
        cyc(0, 4, 0);
        inj = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        rst_n = 1'b0;
        cyc(0, 0, 1);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        req = 4'b1000;
        cyc(8, 0, 0);
        rst_n = 1'b0;
        req   = '0;
        cyc(0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        req = 4'b1111;
        cyc(1, 0, 0);
        req = '0;
        cyc(0, 1, 0);
        req     = 4'b0010;
        mem_off = 1'b1;
        cyc(2, 0, 0);
        mem_off = 1'b0;
        req     = '0;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        rst_n = 1'b0;
        cyc(0, 0, 1);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        req = 4'b0010;
        repeat (NG) cyc(-1, -1, -1);
        req = '0;
        cyc(-1, -1, 0);
        cyc(0, 0, 0);
        chk("lit_grant_cnt1", grant_cnt[31:16], 64'(CNT1));
        chk("lit_grant_cnt0", grant_cnt[15:0], 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
